// File: rtl/mips_commit_monitor_if.sv
// Commit monitor bus: the write-back observation port (wb_*) plus the
// valid/ready record drain port (out_*).
// master : the pipeline/host side (drives write-back, accepts records)
// slave  : the monitor itself
`timescale 1ns/1ps
interface mips_commit_monitor_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [REG_W-1:0]  out_reg;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_cycle;

  modport master (
    output wb_en, wb_reg, wb_data, wb_pc, out_ready,
    input  out_valid, out_pc, out_reg, out_data, out_cycle
  );

  modport slave (
    input  wb_en, wb_reg, wb_data, wb_pc, out_ready,
    output out_valid, out_pc, out_reg, out_data, out_cycle
  );
endinterface

// File: rtl/mips_commit_monitor.sv
// MIPS write-back commit monitor.
// Captures every architectural register write (except $zero) as a
// {pc, reg, data, cycle} record into a first-word-fall-through FIFO that
// drains over a valid/ready port. Counts commits and drops, flags overflow.
// Optional feature macro: MONITOR_HALT_EN -- when defined, halt_req is a
// registered "almost full" stall request (level >= DEPTH-1); otherwise it
// is tied low.
`timescale 1ns/1ps
module mips_commit_monitor #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  mips_commit_monitor_if.slave bus,
  output logic [ADDR_W:0]      level,
  output logic [CNT_W-1:0]     commit_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 overflow,
  output logic                 halt_req
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cyc;
  } rec_t;

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  rec_t              mem [DEPTH];
  rec_t              head;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  commit_q, commit_d;
  logic [15:0]       drop_q, drop_d;
  logic              overflow_q, overflow_d;

  logic              capture, pop, push, drop, full, not_empty;

  // Handshake decode and next-state computation; clear overrides everything.
  always_comb begin
    not_empty  = (level_q != '0);
    full       = (level_q == FULL_LEVEL);
    capture    = enable & bus.wb_en & (bus.wb_reg != '0);
    pop        = not_empty & bus.out_ready;
    push       = capture & (~full | pop);
    drop       = capture & full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cycle_d    = cycle_q;
    commit_d   = commit_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      cycle_d    = '0;
      commit_d   = '0;
      drop_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (enable) cycle_d = cycle_q + 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        commit_d = commit_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      // Full FIFO with push and pop together keeps its level.
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
      end
    end
  end

  // Control and counter state; async reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cycle_q    <= '0;
      commit_q   <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cycle_q    <= cycle_d;
      commit_q   <= commit_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; the timestamp is the counter value before this cycle's increment.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_q] <= '{pc: bus.wb_pc, rg: bus.wb_reg, data: bus.wb_data, cyc: cycle_q};
    end
  end

  // Fall-through head; fields are forced to zero while the FIFO is empty.
  always_comb begin
    head = mem[rd_ptr_q];
    if (!not_empty) head = '0;
  end

  assign bus.out_valid = not_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_reg   = head.rg;
  assign bus.out_data  = head.data;
  assign bus.out_cycle = head.cyc;

  assign level      = level_q;
  assign commit_cnt = commit_q;
  assign drop_cnt   = drop_q;
  assign overflow   = overflow_q;

`ifdef MONITOR_HALT_EN
  localparam logic [ADDR_W:0] HALT_LEVEL = (ADDR_W+1)'(DEPTH-1);
  logic halt_q, halt_d;

  // Stall request tracks the next-cycle occupancy so it lines up with level.
  always_comb begin
    halt_d = (level_d >= HALT_LEVEL);
  end

  // Registered stall request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  assign halt_req = halt_q;
`else
  assign halt_req = 1'b0;
`endif

endmodule

// File: tb/tb_mips_commit_monitor.sv
// Self-checking bench for mips_commit_monitor. Expected records are queued
// when a capture is driven and compared when the DUT hands them out.
`timescale 1ns/1ps
module tb_mips_commit_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  level;
  logic [31:0] commit_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        halt_req;

  mips_commit_monitor_if bus_if ();

  mips_commit_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .bus        (bus_if),
    .level      (level),
    .commit_cnt (commit_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .halt_req   (halt_req)
  );

  always #5 clk = ~clk;

`ifdef MONITOR_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
    logic [31:0] cyc;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cycle = 0;
  logic [100:0] head_obs;
  logic [100:0] head_exp;
  logic        exp_halt;

  assign head_obs = {bus_if.out_pc, bus_if.out_reg, bus_if.out_data, bus_if.out_cycle};

  function automatic logic [100:0] pack_rec(input rec_t r);
    return {r.pc, r.rg, r.data, r.cyc};
  endfunction

  // Advance one clock; the timestamp model follows the inputs held over the edge.
  task automatic tick();
    if (clear)       model_cycle = 0;
    else if (enable) model_cycle = model_cycle + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_commit(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    bus_if.wb_en   = 1'b1;
    bus_if.wb_reg  = r;
    bus_if.wb_data = d;
    bus_if.wb_pc   = pc;
  endtask

  task automatic expect_commit(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    rec_t n;
    n.pc = pc; n.rg = r; n.data = d; n.cyc = model_cycle;
    exp_q.push_back(n);
  endtask

  task automatic test_reset();
    bus_if.wb_en = 1'b0; bus_if.wb_reg = '0; bus_if.wb_data = '0;
    bus_if.wb_pc = '0; bus_if.out_ready = 1'b0;
    #12;
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus_if.out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if ({commit_cnt, drop_cnt, overflow, halt_req} !== 50'd0) begin errors++; $display("FAIL reset_counters got %h/%h/%b/%b want 0", commit_cnt, drop_cnt, overflow, halt_req); end
    checks++; if (head_obs !== 101'd0) begin errors++; $display("FAIL reset_head got %h want 0", head_obs); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    model_cycle = 0;
    $display("test_reset done");
  endtask

  task automatic test_basic_commit();
    enable = 1'b1; bus_if.out_ready = 1'b1;
    repeat (3) tick();
    drive_commit(5'd5, 32'hDEADBEEF, 32'h00000010);
    expect_commit(5'd5, 32'hDEADBEEF, 32'h00000010);
    tick();
    bus_if.wb_en = 1'b0;
    checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", bus_if.out_valid); end
    checks++; if (commit_cnt !== 32'd1) begin errors++; $display("FAIL basic_commit_cnt got %0d want 1", commit_cnt); end
    e = exp_q.pop_front(); head_exp = pack_rec(e);
    checks++; if (head_obs !== head_exp) begin errors++; $display("FAIL basic_record got %h want %h", head_obs, head_exp); end
    tick();
    checks++; if (bus_if.out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL basic_drained got valid=%0b level=%0d want 0/0", bus_if.out_valid, level); end
    $display("test_basic_commit done");
  endtask

  task automatic test_zero_filter();
    clear = 1'b1; tick(); clear = 1'b0; exp_q.delete();
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL zero_clear_cnt got %0d want 0", commit_cnt); end
    drive_commit(5'd0, 32'h12345678, 32'h40);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL zero_level[%0d] got %0d want 0", i, level); end
    end
    bus_if.wb_en = 1'b0;
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL zero_commit_cnt got %0d want 0", commit_cnt); end
    $display("test_zero_filter done");
  endtask

  task automatic test_overflow();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_commit(5'd1, 32'(i), 32'h100 + 32'(4 * i));
      if (i < 16) expect_commit(5'd1, 32'(i), 32'h100 + 32'(4 * i));
      tick();
      checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 32'd0) begin errors++; $display("FAIL ovf_head_stable[%0d] got valid=%0b data=%h want 1/0", i, bus_if.out_valid, bus_if.out_data); end
    end
    bus_if.wb_en = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 4", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (commit_cnt !== 32'd16) begin errors++; $display("FAIL ovf_commit_cnt got %0d want 16", commit_cnt); end
    $display("test_overflow done");
  endtask

  task automatic test_full_pop();
    drive_commit(5'd7, 32'd99, 32'h200);
    bus_if.out_ready = 1'b1;
    e = exp_q.pop_front(); head_exp = pack_rec(e);
    checks++; if (head_obs !== head_exp) begin errors++; $display("FAIL fullpop_head got %h want %h", head_obs, head_exp); end
    expect_commit(5'd7, 32'd99, 32'h200);
    tick();
    bus_if.wb_en = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fullpop_level got %0d want 16", level); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL fullpop_drop_cnt got %0d want 4", drop_cnt); end
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front(); head_exp = pack_rec(e);
      checks++; if (bus_if.out_valid !== 1'b1 || head_obs !== head_exp) begin errors++; $display("FAIL drain_record got valid=%0b %h want 1 %h", bus_if.out_valid, head_obs, head_exp); end
      tick();
    end
    checks++; if (level !== 5'd0 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got level=%0d valid=%0b want 0/0", level, bus_if.out_valid); end
    $display("test_full_pop done");
  endtask

  task automatic test_clear();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_commit(5'd2, 32'hA0 + 32'(i), 32'h300 + 32'(4 * i));
      expect_commit(5'd2, 32'hA0 + 32'(i), 32'h300 + 32'(4 * i));
      tick();
    end
    checks++; if (level !== 5'd7) begin errors++; $display("FAIL clear_pre_level got %0d want 7", level); end
    drive_commit(5'd3, 32'hBB, 32'h400);
    clear = 1'b1;
    tick();
    clear = 1'b0; bus_if.wb_en = 1'b0; exp_q.delete();
    checks++; if (level !== 5'd0 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL clear_level got %0d valid=%0b want 0/0", level, bus_if.out_valid); end
    checks++; if ({commit_cnt, drop_cnt, overflow} !== 49'd0) begin errors++; $display("FAIL clear_counters got %0d/%0d/%0b want 0/0/0", commit_cnt, drop_cnt, overflow); end
    drive_commit(5'd4, 32'h55, 32'h500);
    expect_commit(5'd4, 32'h55, 32'h500);
    tick();
    bus_if.wb_en = 1'b0; bus_if.out_ready = 1'b1;
    e = exp_q.pop_front(); head_exp = pack_rec(e);
    checks++; if (head_obs !== head_exp) begin errors++; $display("FAIL clear_restart_record got %h want %h", head_obs, head_exp); end
    tick();
    $display("test_clear done");
  endtask

  task automatic test_reset_async();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_commit(5'd6, 32'(i), 32'h600);
      tick();
    end
    bus_if.wb_en = 1'b0; enable = 1'b0;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL areset_pre_level got %0d want 3", level); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_if.out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL areset_async got valid=%0b level=%0d want 0/0", bus_if.out_valid, level); end
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL areset_commit_cnt got %0d want 0", commit_cnt); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); model_cycle = 0; enable = 1'b1;
    $display("test_reset_async done");
  endtask

  task automatic test_halt();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_commit(5'd9, 32'hC0 + 32'(i), 32'h700 + 32'(4 * i));
      expect_commit(5'd9, 32'hC0 + 32'(i), 32'h700 + 32'(4 * i));
      tick();
      exp_halt = HALT_ON && (exp_q.size() >= 15);
      checks++; if (halt_req !== exp_halt) begin errors++; $display("FAIL halt_fill[%0d] got %0b want %0b", i, halt_req, exp_halt); end
    end
    bus_if.wb_en = 1'b0; bus_if.out_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front(); head_exp = pack_rec(e);
      checks++; if (bus_if.out_valid !== 1'b1 || head_obs !== head_exp) begin errors++; $display("FAIL halt_drain_record got valid=%0b %h want 1 %h", bus_if.out_valid, head_obs, head_exp); end
      tick();
      exp_halt = HALT_ON && (exp_q.size() >= 15);
      checks++; if (halt_req !== exp_halt) begin errors++; $display("FAIL halt_drain level=%0d got %0b want %0b", level, halt_req, exp_halt); end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL halt_final_level got %0d want 0", level); end
    $display("test_halt done");
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_zero_filter();
    test_overflow();
    test_full_pop();
    test_clear();
    test_reset_async();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_commit_monitor.md
Name: mips_commit_monitor

Overview:
- Observes the MIPS pipeline write-back stage and records every architectural register commit.
- Each commit is stored as a {pc, reg, data, cycle} record in a FIFO.
- Records drain to a host/bench consumer over a valid/ready interface.
- This is the response side of the pipeline stimulus: stimulus drives clk/reset into the core; this block captures what the core produces.

Parameters:
- DATA_W, 32, width of write-back data and PC.
- REG_W, 5, register index width.
- DEPTH, 16, FIFO entries (power of two).
- ADDR_W, 4, log2(DEPTH).
- CNT_W, 32, width of the cycle and commit counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  capture/timestamp enable.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- wb_en  in  1  write-back register write enable from the pipeline.
- wb_reg  in  REG_W  write-back destination register.
- wb_data  in  DATA_W  write-back data.
- wb_pc  in  DATA_W  PC of the committing instruction.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_pc  out  DATA_W  head record PC.
- out_reg  out  REG_W  head record register.
- out_data  out  DATA_W  head record data.
- out_cycle  out  CNT_W  head record timestamp.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- commit_cnt  out  CNT_W  records accepted into the FIFO.
- drop_cnt  out  16  records lost to a full FIFO.
- overflow  out  1  sticky: at least one drop since reset/clear.
- halt_req  out  1  stall request (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, so out_valid=0 and level=0.
  - cycle counter, commit_cnt and drop_cnt = 0; overflow=0; halt_req=0.
  - out_pc, out_reg, out_data and out_cycle read 0 while empty.
- Cycle counter:
  - Increments every clk while enable=1 and clear=0.
  - Wraps from 2^CNT_W-1 to 0.
- Capture condition: enable & wb_en & (wb_reg != 0). Writes to $zero are never recorded.
- Record contents: wb_pc, wb_reg, wb_data, and the cycle counter value before the increment in that cycle.
- Push and pop:
  - Pop = out_valid & out_ready.
  - Push = capture & (level < DEPTH | pop).
  - A full FIFO with a simultaneous pop still accepts the push; level is unchanged.
- Drop:
  - Occurs when capture & level==DEPTH & !pop.
  - drop_cnt increments, saturating at 16'hFFFF; overflow sets to 1.
  - commit_cnt does not change.
- commit_cnt: increments on each push and wraps.
- FIFO is first-word-fall-through:
  - out_* always present the head entry; out_valid = (level != 0).
  - Capture-to-out_valid latency is 1 clk. There is no same-cycle bypass.
  - Push and pop in the same cycle on an empty FIFO cannot happen, since out_valid=0.
- Handshake:
  - out_* hold stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
- Pointers: ADDR_W-bit read/write pointers wrap modulo DEPTH. level tracks occupancy independently of the pointers.
- Clear:
  - Synchronous, and takes priority over push, pop and counting.
  - Next cycle: level=0, all counters 0, overflow=0.
  - A capture in the clear cycle is discarded and not counted as a drop.
- Reset mid-transfer: all records are lost; out_valid falls asynchronously.
- enable=0: no capture and no timestamp increment. Draining continues normally.

Optional Feature:
- Macro: MONITOR_HALT_EN.
- Defined: halt_req is a registered output, set when the next-state level >= DEPTH-1 and cleared when level < DEPTH-1. The pipeline uses it to stall write-back before drops occur.
- Undefined: halt_req is tied to 0. Drops are the only overflow indication.

Test Plan:
- Basic commit:
  - Stimulus: reset release, enable=1, out_ready=1; one cycle of wb_en=1, wb_reg=5, wb_data=32'hDEADBEEF, wb_pc=32'h00000010 at cycle count 3.
  - Response: out_valid=1 on the next clk with out_reg=5, out_data=DEADBEEF, out_pc=10, out_cycle=3; commit_cnt=1.
- $zero filter: wb_en=1, wb_reg=0 for 4 cycles -> level stays 0, commit_cnt=0.
- Overflow:
  - Stimulus: out_ready=0; 20 consecutive valid commits to reg 1 with data 0..19.
  - Response: level=16, drop_cnt=4, overflow=1.
  - Draining then yields data 0..15 in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 and a capture in the same cycle.
  - Response: level stays 16, drop_cnt unchanged, the new record is at the tail.
- Clear and reset priority:
  - clear=1 while level=7 with a capture -> next cycle level=0, counters 0, overflow=0.
  - reset=0 asserted mid-cycle -> out_valid drops immediately, without waiting for clk.
- MONITOR_HALT_EN (bench compiled with the macro):
  - Filling to 15 entries -> halt_req=1.
  - Draining to 14 -> halt_req=0.
  - Without the macro, halt_req stays 0 throughout.
